ram_req_ctrl: RTL and testbench
===============================

// Module: ram_req_ctrl
// PURPOSE
//  Request sequencer directly upstream of the 16x8 synchronous RAM.
//  Accepts read/write requests over a valid/ready handshake and drives the RAM's we/addr/din.
//  Captures the RAM's registered dout and returns read data over a valid/ready response channel.
//  Owns all RAM sequencing, so clients never deal with RAM latency or the hold-dout-on-write rule.
// PARAMETERS
//  ADDR_W  4  RAM address width; DEPTH = 2**ADDR_W is a derived localparam (16)
//  DATA_W  8  RAM data width
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept a request
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  request address
//  req_wdata  in   DATA_W  write data, ignored for reads
//  rsp_valid  out  1       read data valid
//  rsp_ready  in   1       consumer accepts read data
//  rsp_rdata  out  DATA_W  read data
//  busy       out  1       high in any state other than IDLE
//  ram_we     out  1       to RAM we
//  ram_addr   out  ADDR_W  to RAM addr
//  ram_din    out  DATA_W  to RAM din
//  ram_dout   in   DATA_W  from RAM dout
// BEHAVIOUR
//  Reset: state=IDLE (CLEAR if macro), ram_we=0, ram_addr=0, ram_din=0, rsp_valid=0, rsp_rdata=0.
//  Reset is asynchronous and takes effect immediately, including mid-operation.
//  An in-flight write may or may not land; an in-flight read is dropped with no response.
//  Registered outputs: ram_*, rsp_valid, rsp_rdata. req_ready = (state==IDLE) and busy are decoded from state.
//  A request is accepted when req_valid && req_ready at a posedge. Only one transaction is outstanding at a time.
//  FSM:
//   IDLE: on accept, register ram_addr=req_addr, ram_din=req_wdata, ram_we=req_we.
//         Go to WR if req_we=1, else RD_ISSUE.
//   WR: the RAM commits the write at this edge. Then ram_we<=0 and go to IDLE.
//       Writes produce no response; write throughput is 1 per 2 cycles.
//   RD_ISSUE: ram_we=0 and ram_addr is held; the RAM loads dout at this edge. Go to RD_CAP.
//   RD_CAP: rsp_rdata<=ram_dout, rsp_valid<=1. Go to RESP.
//   RESP: hold rsp_valid and rsp_rdata stable while rsp_ready=0.
//         On rsp_valid && rsp_ready, rsp_valid<=0 and go to IDLE.
//  Read latency: rsp_valid rises exactly 2 cycles after the accept edge (0-wait consumer).
//  ram_addr and ram_din hold their last value in IDLE. ram_we is high only in the WR/CLEAR cycle.
//  A read immediately after a write to the same address returns the new data, because the write commits before the next accept.
//  No address range check is needed: every ADDR_W value is a legal location (0..DEPTH-1).
//  Illegal state encodings recover to IDLE.
// CONFIGURATION
//  RAM_CTRL_CLEAR_EN defined: after reset, the CLEAR state writes 0 to addresses 0..DEPTH-1, one per cycle
//   (ram_we=1, ram_din=0, ram_addr=counter). req_ready=0 and busy=1 during the sweep.
//   After address DEPTH-1 the counter stops (no wrap) and the FSM enters IDLE. The sweep takes DEPTH cycles.
//   A reset during the sweep restarts it at address 0.
//  RAM_CTRL_CLEAR_EN undefined: no CLEAR state and no counter. Reset goes straight to IDLE; RAM contents are undefined until written.
// STRUCTURE
//  ram_ctrl_pkg holds the state enum (IDLE, WR, RD_ISSUE, RD_CAP, RESP, CLEAR) and the default ADDR_W/DATA_W constants.
//  ram_req_ctrl is a single module with no sub-module.
//  The top level instantiates ram_req_ctrl and simple_sync_ram side by side, with the ram_* ports connected directly.
// TESTING (bench pairs ram_req_ctrl with the real RAM)
//  1 Write 0xA5 to addr 3, then read addr 3 -> rsp_rdata=0xA5, with rsp_valid rising 2 cycles after the read accept.
//  2 Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, busy=1.
//    Then rsp_ready=1 -> one beat, and req_ready=1 the next cycle.
//  3 Back-to-back writes addr i -> data 8'h10+i for i=0..15, then read all 16 -> each returns 8'h10+i.
//    Accept spacing is exactly 2 cycles for the writes.
//  4 Assert rst_n=0 in RD_CAP -> ram_we=0 and rsp_valid=0 immediately, with no response after release.
//    A new read of addr 3 (still 0xA5 from scenario 1) returns 0xA5.
//  5 Hold req_valid=1 with a write and rsp_ready=1 continuously -> no request accepted outside IDLE,
//    and no double accept of one request.
//  6 With RAM_CTRL_CLEAR_EN: after reset, req_ready=0 for 16 cycles, ram_we=1 with addr 0..15.
//    Then reading addr 7 and 15 -> 0x00.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM request controller: default RAM geometry
// and the controller state encoding.
package ram_ctrl_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAP   = 3'd3,
        RESP     = 3'd4,
        CLEAR    = 3'd5
    } state_t;

endpackage

// File: rtl/simple_sync_ram.sv
// Single-port synchronous RAM with registered read data. The read register
// holds its previous value on write cycles.
module simple_sync_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port, or registered read when not writing
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request sequencer in front of a synchronous RAM. Accepts one read or write
// at a time over valid/ready, hides the RAM read latency and returns read
// data over a valid/ready response channel.
// Optional build macro RAM_CTRL_CLEAR_EN: zero the whole RAM after reset
// before the first request is accepted.
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

`ifdef RAM_CTRL_CLEAR_EN
    localparam int                DEPTH       = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam state_t            RESET_STATE = CLEAR;
`else
    localparam state_t            RESET_STATE = IDLE;
`endif

    state_t            state_q, state_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef RAM_CTRL_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

    // State and registered RAM/response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef RAM_CTRL_CLEAR_EN
    // Sweep address counter; restarts from 0 on every reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef RAM_CTRL_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ram_addr_d = req_addr;
                    ram_din_d  = req_wdata;
                    ram_we_d   = req_we;
                    state_d    = req_we ? WR : RD_ISSUE;
                end
            end
            WR: begin
                // RAM commits the write at this edge
                ram_we_d = 1'b0;
                state_d  = IDLE;
            end
            RD_ISSUE: begin
                // RAM loads dout from the held address at this edge
                ram_we_d = 1'b0;
                state_d  = RD_CAP;
            end
            RD_CAP: begin
                rsp_rdata_d = ram_dout;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
`ifdef RAM_CTRL_CLEAR_EN
            CLEAR: begin
                // Counter parks on the last address rather than wrapping
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                ram_we_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef RAM_CTRL_CLEAR_EN
    // During the sweep the RAM port is driven straight from the registered
    // state and counter so that every sweep cycle is a write.
    assign ram_we   = ram_we_q | (state_q == CLEAR);
    assign ram_addr = (state_q == CLEAR) ? clr_cnt_q : ram_addr_q;
    assign ram_din  = (state_q == CLEAR) ? '0 : ram_din_q;
`else
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
`endif

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl paired with simple_sync_ram.
module tb_ram_req_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    ram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    simple_sync_ram #(.ADDR_W(AW), .DATA_W(DW)) ram (
        .clk(clk), .we(ram_we), .addr(ram_addr), .din(ram_din), .dout(ram_dout)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_beat = 0;
    int n_we = 0;
    int n_rspv = 0;

    // Reference memory: what every location must hold from the client's view
    logic [DW-1:0] model [16];

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [8];

    // Event counters sampled at the active edge
    always @(posedge clk) begin
        cyc++;
        if (req_valid && req_ready) n_acc++;
        if (rsp_valid && rsp_ready) n_beat++;
        if (ram_we) n_we++;
        if (rsp_valid) n_rspv++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present one request, wait for it to be taken, drop valid after the accept edge
    task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc_cyc);
        int n;
        int a0;
        n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        a0 = n_acc;
        @(negedge clk);
        acc_cyc = cyc;
        req_valid = 1'b0;
        chk("single_accept", n_acc - a0, 32'd1);
        if (we) model[a] = d;
    endtask

    // Read and check data, latency and (optionally under random stalls) hold stability
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input bit stall);
        int acc;
        int n;
        int k;
        int b0;
        b0 = n_beat;
        rsp_ready = 1'b1;
        send(1'b0, a, '0, acc);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        chk("read_latency", cyc - acc, 32'd2);
        chk("read_data", {24'd0, rsp_rdata}, {24'd0, exp});
        k = 0;
        while (rsp_valid && k < 40) begin
            rsp_ready = stall ? ((k >= 8) || ($urandom_range(0, 1) == 1)) : 1'b1;
            @(negedge clk);
            if (rsp_valid) chk("rsp_hold_data", {24'd0, rsp_rdata}, {24'd0, exp});
            k++;
        end
        rsp_ready = 1'b1;
        chk("rsp_drained", {31'd0, rsp_valid}, 32'd0);
        chk("one_beat", n_beat - b0, 32'd1);
    endtask

    // Release reset at a falling edge; with the clear sweep, follow it address by address
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
`ifdef RAM_CTRL_CLEAR_EN
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("sweep_we", {31'd0, ram_we}, 32'd1);
            chk("sweep_addr", {28'd0, ram_addr}, i);
            chk("sweep_din", {24'd0, ram_din}, 32'd0);
            chk("sweep_not_ready", {31'd0, req_ready}, 32'd0);
            chk("sweep_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
            #1;
        end
        chk("sweep_done_ready", {31'd0, req_ready}, 32'd1);
        chk("sweep_done_we", {31'd0, ram_we}, 32'd0);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
`endif
    endtask

    initial begin
        int acc;
        int prev;
        int a0;
        int w0;
        int b0;
        int r0;
        bit we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        tbl[0] = '{1'b1, 4'd3, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 4'd3, 8'h00, 8'hA5};
        tbl[2] = '{1'b1, 4'd9, 8'h3C, 8'h00};
        tbl[3] = '{1'b1, 4'd9, 8'hC3, 8'h00};
        tbl[4] = '{1'b0, 4'd9, 8'h00, 8'hC3};
        tbl[5] = '{1'b1, 4'd0, 8'hFF, 8'h00};
        tbl[6] = '{1'b0, 4'd0, 8'h00, 8'hFF};
        tbl[7] = '{1'b0, 4'd3, 8'h00, 8'hA5};

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_ram_din", {24'd0, ram_din}, 32'd0);
        chk("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
`ifdef RAM_CTRL_CLEAR_EN
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
`else
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`endif
        release_reset();

`ifdef RAM_CTRL_CLEAR_EN
        do_read(4'd7, 8'h00, 1'b0);
        do_read(4'd15, 8'h00, 1'b0);
`endif

        // Directed table, including write-then-read of the same address
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].we) send(1'b1, tbl[i].addr, tbl[i].data, acc);
            else do_read(tbl[i].addr, tbl[i].exp, 1'b0);
        end

        // Response back-pressure: hold for 5 cycles, then release for one beat
        rsp_ready = 1'b0;
        send(1'b0, 4'd3, '0, acc);
        a0 = 0;
        while (!rsp_valid && a0 < 20) begin
            @(negedge clk);
            a0++;
        end
        chk("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data_hold", {24'd0, rsp_rdata}, 32'hA5);
            chk("bp_not_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
        end
        b0 = n_beat;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_beats", n_beat - b0, 32'd1);
        chk("bp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("bp_ready_back", {31'd0, req_ready}, 32'd1);

        // Reset while the read sits in RD_CAP
        send(1'b0, 4'd3, '0, acc);
        @(negedge clk);
        r0 = n_rspv;
        b0 = n_beat;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
`ifndef RAM_CTRL_CLEAR_EN
        chk("midrst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
`endif
        release_reset();
        repeat (6) @(negedge clk);
        chk("midrst_no_rsp", n_rspv - r0, 32'd0);
        chk("midrst_no_beat", n_beat - b0, 32'd0);
        do_read(4'd3, model[3], 1'b0);

        // Back-to-back writes, then read every location
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            d = 8'h10 + 8'(i);
            send(1'b1, 4'(i), d, acc);
            if (i > 0) chk("wr_spacing", acc - prev, 32'd2);
            prev = acc;
        end
        for (int i = 0; i < 16; i++) begin
            d = 8'h10 + 8'(i);
            do_read(4'(i), d, 1'b0);
        end

        // Write request held valid across several cycles
        a0 = n_acc;
        w0 = n_we;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'h5A;
        repeat (10) @(negedge clk);
        req_valid = 1'b0;
        model[5] = 8'h5A;
        chk("hold_accepts", n_acc - a0, 32'd5);
        chk("hold_we_pulses", n_we - w0, 32'd5);
        chk("hold_we_low", {31'd0, ram_we}, 32'd0);
        do_read(4'd5, 8'h5A, 1'b0);

        // Random traffic against the reference memory
        for (int i = 0; i < 60; i++) begin
            we = ($urandom_range(0, 1) == 1);
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            if (we) send(1'b1, a, d, acc);
            else do_read(a, model[a], 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
